// File: rtl/aclk_pkg.sv
// Shared types and constants for the alarm-clock keypad/button controller.
package aclk_pkg;

    typedef enum logic [2:0] {
        SHOW_TIME        = 3'd0,
        KEY_STORED       = 3'd1,
        KEY_WAITED       = 3'd2,
        KEY_ENTRY        = 3'd3,
        SHOW_ALARM       = 3'd4,
        SET_ALARM_TIME   = 3'd5,
        SET_CURRENT_TIME = 3'd6
    } aclk_state_t;

    localparam logic [3:0] NOKEY = 4'hA;
    localparam int TIMEOUT_SEC_DEF = 10;

    // Anything outside 0-9 behaves like NOKEY.
    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/aclk_key_timer.sv
// Saturating key-entry timeout counter; timeout is the compare of the count register.
module aclk_key_timer
    import aclk_pkg::*;
#(
    parameter int TIMEOUT_SEC = TIMEOUT_SEC_DEF,
    parameter int TMR_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic tick,
    output logic timeout
);

    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_SEC);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (count == LIMIT);

endmodule

// File: rtl/aclk_ctrl_fsm.sv
// Alarm-clock keypad/button sequencing FSM (Moore outputs).
// Key-entry timeout is built only when ACLK_KEY_TIMEOUT_EN is defined.
//
// state            | meaning
// SHOW_TIME        | idle, display shows current time
// KEY_STORED       | one-cycle shift of the pressed digit
// KEY_WAITED       | waiting for the digit key to be released
// KEY_ENTRY        | entry in progress, waiting for next key or a button
// SHOW_ALARM       | display alarm while ALARM is held
// SET_ALARM_TIME   | one-cycle commit of entry into alarm register
// SET_CURRENT_TIME | one-cycle commit of entry into current time
module aclk_ctrl_fsm
    import aclk_pkg::*;
#(
    parameter int TIMEOUT_SEC = TIMEOUT_SEC_DEF,
    parameter int TMR_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_sec,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic       shift,
    output logic       show_new_time,
    output logic       show_a,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       reset_count
);

    aclk_state_t state_q, state_d;
    logic        digit;
    logic        timeout;

    assign digit = is_digit(key);

`ifdef ACLK_KEY_TIMEOUT_EN
    logic timer_clr;

    assign timer_clr = (state_q != KEY_WAITED) && (state_q != KEY_ENTRY);

    aclk_key_timer #(
        .TIMEOUT_SEC (TIMEOUT_SEC),
        .TMR_W       (TMR_W)
    ) u_key_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .tick    (one_sec),
        .timeout (timeout)
    );
`else
    // Without the timer, one_sec and the timer sizing have no consumer.
    logic             unused_one_sec;
    logic [TMR_W-1:0] unused_tmr_limit;

    assign unused_one_sec   = one_sec;
    assign unused_tmr_limit = TMR_W'(TIMEOUT_SEC);
    assign timeout          = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SHOW_TIME;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SHOW_TIME: begin
                if (alarm_button)  state_d = SHOW_ALARM;
                else if (digit)    state_d = KEY_STORED;
            end
            KEY_STORED:            state_d = KEY_WAITED;
            KEY_WAITED: begin
                if (!digit)        state_d = KEY_ENTRY;
                else if (timeout)  state_d = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (alarm_button)     state_d = SET_ALARM_TIME;
                else if (time_button) state_d = SET_CURRENT_TIME;
                else if (digit)       state_d = KEY_STORED;
                else if (timeout)     state_d = SHOW_TIME;
            end
            SHOW_ALARM: begin
                if (!alarm_button) state_d = SHOW_TIME;
            end
            SET_ALARM_TIME:        state_d = SHOW_TIME;
            SET_CURRENT_TIME:      state_d = SHOW_TIME;
            default:               state_d = SHOW_TIME;
        endcase
    end

    always_comb begin
        shift         = 1'b0;
        show_new_time = 1'b0;
        show_a        = 1'b0;
        load_new_a    = 1'b0;
        load_new_c    = 1'b0;
        reset_count   = 1'b0;
        case (state_q)
            KEY_STORED: begin
                shift         = 1'b1;
                show_new_time = 1'b1;
            end
            KEY_WAITED:       show_new_time = 1'b1;
            KEY_ENTRY:        show_new_time = 1'b1;
            SHOW_ALARM:       show_a        = 1'b1;
            SET_ALARM_TIME:   load_new_a    = 1'b1;
            SET_CURRENT_TIME: begin
                load_new_c  = 1'b1;
                reset_count = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/aclk_ctrl_fsm.md
# aclk_ctrl_fsm

Keypad/button sequencing controller for the alarm clock. It watches the digit keypad and the ALARM/TIME buttons, steers the key-entry shift register and display mux, and commits entered values into the alarm or current-time registers. It issues `reset_count` to the time generator when a new current time is loaded, and consumes its `one_sec` pulse for the key-entry timeout.

## Interface
Parameters:
- `TIMEOUT_SEC`, default 10: `one_sec` pulses without a key press before key entry is abandoned.
- `TMR_W`, default 4: timeout counter width; must hold `TIMEOUT_SEC`.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `one_sec`, in, 1: single-cycle pulse from the time generator.
- `key`, in, 4: keypad code. 0–9 are digits; `NOKEY` (4'hA) means no key. Other codes are treated as `NOKEY`.
- `alarm_button`, in, 1: level, synchronous to `clk`.
- `time_button`, in, 1: level, synchronous to `clk`.
- `shift`, out, 1: shift `key` into the entry register.
- `show_new_time`, out, 1: display selects the entry register.
- `show_a`, out, 1: display selects the alarm register.
- `load_new_a`, out, 1: load the entry register into the alarm register.
- `load_new_c`, out, 1: load the entry register into the current-time counter.
- `reset_count`, out, 1: clear the time-generator prescaler.

## Operation
Moore FSM. All outputs are decoded from the state register only.

States and outputs (any output not listed is 0):
- `SHOW_TIME`: all outputs 0.
- `KEY_STORED`: `shift`=1, `show_new_time`=1.
- `KEY_WAITED`: `show_new_time`=1.
- `KEY_ENTRY`: `show_new_time`=1.
- `SHOW_ALARM`: `show_a`=1.
- `SET_ALARM_TIME`: `load_new_a`=1.
- `SET_CURRENT_TIME`: `load_new_c`=1, `reset_count`=1.

Transitions, listed in priority order within each state:
- `SHOW_TIME`:
  - `alarm_button` → `SHOW_ALARM`.
  - Else digit key → `KEY_STORED`.
  - Else stay. `time_button` alone is ignored.
- `KEY_STORED` → `KEY_WAITED`, unconditionally.
- `KEY_WAITED` (waiting for key release):
  - `key`==`NOKEY` → `KEY_ENTRY`.
  - Else timeout → `SHOW_TIME`.
  - Else stay.
- `KEY_ENTRY`:
  - `alarm_button` → `SET_ALARM_TIME`.
  - Else `time_button` → `SET_CURRENT_TIME`.
  - Else digit key → `KEY_STORED`.
  - Else timeout → `SHOW_TIME`.
  - Else stay.
- `SHOW_ALARM`: `!alarm_button` → `SHOW_TIME`, else stay.
- `SET_ALARM_TIME` and `SET_CURRENT_TIME` → `SHOW_TIME`, unconditionally.

Timeout counter:
- Clears to 0 in every state except `KEY_WAITED` and `KEY_ENTRY`.
- In those two states it increments on each `one_sec` pulse.
- Timeout is true when counter == `TIMEOUT_SEC` (registered compare).
- Counter saturates at `TIMEOUT_SEC`; it never wraps.
- Entering `KEY_STORED` clears it, so every key press restarts the full timeout window.

## Timing
- Reset: state = `SHOW_TIME`, counter = 0, every output = 0, applied immediately (asynchronous). Reset mid-entry abandons the entry; no load pulse is produced.
- Latency: an input sampled at edge N affects outputs after edge N (one state register).
- `shift` is exactly one cycle wide per key press, however long the key is held. A held key generates no further shifts until it is released and pressed again.
- `load_new_a`, `load_new_c`, `reset_count` are each exactly one cycle wide. `reset_count` is coincident with `load_new_c`.
- Timeout: the state leaves `KEY_ENTRY`/`KEY_WAITED` one cycle after the `TIMEOUT_SEC`-th `one_sec` pulse counted.
- Simultaneous events:
  - Both buttons in `KEY_ENTRY`: alarm wins.
  - Button and timeout in the same cycle: button wins.
  - Digit key and timeout in `KEY_ENTRY` in the same cycle: the key wins.

## Configuration
- `ACLK_KEY_TIMEOUT_EN` defined: timeout counter and the timeout transitions are present, as described above.
- `ACLK_KEY_TIMEOUT_EN` undefined:
  - No counter is built; `one_sec` is ignored, but the port remains.
  - `KEY_WAITED` and `KEY_ENTRY` never time out. They exit only via key release, a key press, or a button.

## Structure
- Package `aclk_pkg` holds:
  - The state enum typedef (binary-encoded).
  - The `NOKEY` = 4'hA constant.
  - The default `TIMEOUT_SEC` constant.
- Sub-module `aclk_key_timer` implements the saturating timeout counter: inputs `clr`, `tick`; output `timeout`. It is instantiated only under `ACLK_KEY_TIMEOUT_EN`.

## Test plan
- Reset, then hold `key`=`NOKEY` with no buttons for 100 cycles → all outputs 0, state `SHOW_TIME`.
- Press key 3 for 5 cycles, release, press key 7 for 5 cycles, release, pulse `time_button` → `shift` gives exactly 2 one-cycle pulses, then `load_new_c`=`reset_count`=1 for 1 cycle, then `SHOW_TIME`.
- Enter digit 5, then pulse `alarm_button` → `load_new_a`=1 for 1 cycle; `show_a` stays 0 that cycle.
- From `SHOW_TIME`, hold `alarm_button` for 20 cycles → `show_a`=1 from cycle 2 through one cycle after release; `load_new_a` never asserts.
- Enter one digit, then deliver 10 `one_sec` pulses with no key → `show_new_time` drops one cycle after the 10th pulse. Repeat with a key at pulse 9 → no timeout; the counter restarts. With the macro undefined → no timeout after 50 pulses.
- In `KEY_ENTRY`, assert `alarm_button`, `time_button` and a `one_sec` pulse in the same cycle → `load_new_a` only. Asserting `reset` during `KEY_STORED` → `shift` drops immediately; the next state is `SHOW_TIME`.
